// File: rtl/mmio_mover_pkg.sv
// Shared types and helpers for the MMIO block mover: FSM state encoding,
// slot/register field widths and an address builder.
package mmio_mover_pkg;

  localparam int SLOT_W      = 6;
  localparam int REG_W       = 5;
  localparam int MMIO_ADDR_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Slot number lands in bits [10:5], register number in bits [4:0].
  function automatic logic [MMIO_ADDR_W-1:0] mmio_addr_of(
    input logic [SLOT_W-1:0] slot,
    input logic [REG_W-1:0]  reg_num
  );
    return {10'd0, slot, reg_num};
  endfunction

endpackage

// File: rtl/mmio_block_mover_if.sv
// FPro MMIO bus bundle as seen by a bus master (master modport) and by the
// slot controller answering it (slave modport).
interface mmio_block_mover_if
  import mmio_mover_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W
);
  logic              mmio_cs;
  logic              mmio_rd;
  logic              mmio_wr;
  logic [ADDR_W-1:0] mmio_addr;
  logic [31:0]       mmio_wr_data;
  logic [31:0]       mmio_rd_data;

  modport master (
    output mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
    input  mmio_rd_data
  );

  modport slave (
    input  mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data,
    output mmio_rd_data
  );
endinterface

// File: rtl/mmio_mover_addr_gen.sv
// Loadable word-address register with an optional +1 step that wraps modulo
// 2^ADDR_W; exposes the value it will hold after the coming clock edge.
module mmio_mover_addr_gen
  import mmio_mover_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr_next
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_r;

  // Load has priority over the step; otherwise hold.
  always_comb begin
    addr_next = addr_r;
    if (load) begin
      addr_next = load_addr;
    end else if (adv) begin
      addr_next = addr_r + ADDR_ONE;
    end else begin
      addr_next = addr_r;
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r <= '0;
    end else begin
      addr_r <= addr_next;
    end
  end

endmodule

// File: rtl/mmio_block_mover.sv
// FPro MMIO bus master that copies a block of 32-bit words between slot
// register ranges; defining MMIO_MOVER_FILL_EN adds a constant-fill mode.
module mmio_block_mover
  import mmio_mover_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = MMIO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  len,
  input  logic              src_inc,
  input  logic              dst_inc,
`ifdef MMIO_MOVER_FILL_EN
  input  logic              fill_mode,
  input  logic [31:0]       fill_data,
`endif
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  words_done,
  mmio_block_mover_if.master bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic              accept_s, step_s, fill_now_s;
  logic [CNT_W-1:0]  rem_r, rem_s;
  logic [CNT_W-1:0]  words_done_r, words_done_s;
  logic              aborted_r, aborted_s;
  logic              busy_r, done_r;
  logic              src_inc_r, dst_inc_r;
  logic [ADDR_W-1:0] src_next_s, dst_next_s;
  logic              cs_r, rd_r, wr_r;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]       wr_data_r, wr_data_s;
`ifdef MMIO_MOVER_FILL_EN
  logic              fill_mode_r;
  logic [31:0]       fill_data_r, fill_word_s;
`endif

  assign accept_s = (state_r == IDLE) && start && !abort;
  assign step_s   = (state_r == WR);

  // In the accept cycle the live inputs decide the mode, afterwards the latched copy.
`ifdef MMIO_MOVER_FILL_EN
  assign fill_now_s  = (state_r == IDLE) ? fill_mode : fill_mode_r;
  assign fill_word_s = (state_r == IDLE) ? fill_data : fill_data_r;
`else
  assign fill_now_s  = 1'b0;
`endif

  mmio_mover_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s),
    .load_addr (src_addr),
    .adv       (step_s && src_inc_r),
    .addr_next (src_next_s)
  );

  mmio_mover_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s),
    .load_addr (dst_addr),
    .adv       (step_s && dst_inc_r),
    .addr_next (dst_next_s)
  );

  // Next-state logic; a WR cycle always finishes its write before aborting.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (len == '0) begin
          state_s = DONE;
        end else if (fill_now_s) begin
          state_s = WR;
        end else begin
          state_s = RD;
        end
      end
      RD: begin
        if (abort) begin
          state_s = DONE;
        end else begin
          state_s = WR;
        end
      end
      WR: begin
        if (abort || (rem_r == CNT_ONE)) begin
          state_s = DONE;
        end else if (fill_now_s) begin
          state_s = WR;
        end else begin
          state_s = RD;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Remaining count, completed-write count and sticky abort flag.
  always_comb begin
    rem_s        = rem_r;
    words_done_s = words_done_r;
    aborted_s    = aborted_r;
    if (accept_s) begin
      rem_s        = len;
      words_done_s = '0;
      aborted_s    = 1'b0;
    end else if (step_s) begin
      rem_s        = rem_r - CNT_ONE;
      words_done_s = words_done_r + CNT_ONE;
      aborted_s    = aborted_r | abort;
    end else if (state_r == RD) begin
      aborted_s    = aborted_r | abort;
    end else begin
      rem_s        = rem_r;
      words_done_s = words_done_r;
      aborted_s    = aborted_r;
    end
  end

  // Bus address and write data for the cycle about to start.
  always_comb begin
    addr_s    = '0;
    wr_data_s = '0;
    case (state_s)
      RD: addr_s = src_next_s;
      WR: begin
        addr_s = dst_next_s;
`ifdef MMIO_MOVER_FILL_EN
        if (fill_now_s) begin
          wr_data_s = fill_word_s;
        end else begin
          wr_data_s = bus.mmio_rd_data;
        end
`else
        wr_data_s = bus.mmio_rd_data;
`endif
      end
      default: begin
        addr_s    = '0;
        wr_data_s = '0;
      end
    endcase
  end

  // State, counters, latched config and registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      rem_r        <= '0;
      words_done_r <= '0;
      aborted_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      src_inc_r    <= 1'b0;
      dst_inc_r    <= 1'b0;
      cs_r         <= 1'b0;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      addr_r       <= '0;
      wr_data_r    <= '0;
`ifdef MMIO_MOVER_FILL_EN
      fill_mode_r  <= 1'b0;
      fill_data_r  <= '0;
`endif
    end else begin
      state_r      <= state_s;
      rem_r        <= rem_s;
      words_done_r <= words_done_s;
      aborted_r    <= aborted_s;
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_s == DONE);
      cs_r         <= (state_s == RD) || (state_s == WR);
      rd_r         <= (state_s == RD);
      wr_r         <= (state_s == WR);
      addr_r       <= addr_s;
      wr_data_r    <= wr_data_s;
      if (accept_s) begin
        src_inc_r   <= src_inc;
        dst_inc_r   <= dst_inc;
`ifdef MMIO_MOVER_FILL_EN
        fill_mode_r <= fill_mode;
        fill_data_r <= fill_data;
`endif
      end
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign aborted          = aborted_r;
  assign words_done       = words_done_r;
  assign bus.mmio_cs      = cs_r;
  assign bus.mmio_rd      = rd_r;
  assign bus.mmio_wr      = wr_r;
  assign bus.mmio_addr    = addr_r;
  assign bus.mmio_wr_data = wr_data_r;

endmodule

// File: doc/mmio_block_mover.md
# mmio_block_mover

Bus-initiator counterpart to the MMIO slot subsystem. It drives the FPro MMIO bus as a master and copies a block of 32-bit words from one slot/register address range to another. Typical use is moving UART RX data into a user slot, or preloading the SSEG or GPO registers, without processor involvement. It sits beside the processor on an arbitrated FPro MMIO port and uses the same `mmio_*` signalling that the slot controller responds to.

## Interface
- `CNT_W`, 16: width of the word-count field and of `words_done`.
- `ADDR_W`, 21: MMIO address width. Bits [10:5] select the slot and bits [4:0] select the register.

Ports (clock and reset first):
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `abort` input 1: terminates the transfer early.
- `src_addr` input ADDR_W: first source address.
- `dst_addr` input ADDR_W: first destination address.
- `len` input CNT_W: number of words to move.
- `src_inc` input 1: 1 means the source address increments by 1 per word; 0 means fixed (FIFO-style register).
- `dst_inc` input 1: same rule for the destination address.
- `fill_mode` input 1: selects fill instead of copy; present only with `MMIO_MOVER_FILL_EN`.
- `fill_data` input 32: constant written in fill mode; present only with `MMIO_MOVER_FILL_EN`.
- `busy` output 1: high from the cycle after start is accepted until DONE is left.
- `done` output 1: one-cycle completion pulse.
- `aborted` output 1: set at done if the transfer was aborted; holds until the next accepted start.
- `words_done` output CNT_W: count of completed writes.
- `mmio_cs` output 1: FPro bus chip select.
- `mmio_rd` output 1: FPro bus read strobe.
- `mmio_wr` output 1: FPro bus write strobe.
- `mmio_addr` output ADDR_W: FPro bus address.
- `mmio_wr_data` output 32: FPro bus write data.
- `mmio_rd_data` input 32: FPro bus read data, valid combinationally in the same cycle as `mmio_rd`.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - `start`=1 and `abort`=0 → latch all config inputs, clear `words_done` and `aborted`.
  - Then go to RD, or to WR if fill mode is active. If `len`=0, go to DONE instead.
  - `start` and `abort` together in IDLE: abort wins; the request is ignored and nothing happens.
- RD:
  - Drive `mmio_cs`=1, `mmio_rd`=1, `mmio_addr`=current source address.
  - Capture `mmio_rd_data` into the data register at the clock edge, then go to WR.
- WR:
  - Drive `mmio_cs`=1, `mmio_wr`=1, `mmio_addr`=current destination address, `mmio_wr_data`=data register (or `fill_data` in fill mode).
  - At the edge: increment `words_done`, and advance each address whose inc bit is set.
  - If the remaining count reaches 0, go to DONE; otherwise go to RD (or stay in WR in fill mode).
- DONE: pulse `done` for one cycle, then return to IDLE.
- Abort:
  - `abort` in RD → DONE with no write; `aborted`=1.
  - `abort` in WR → the current write completes, then DONE; `aborted`=1.
- `start` while busy is ignored. Config inputs are don't-care outside the accept cycle.
- Address increment is modulo 2^ADDR_W, so 21'h1FFFFF+1 = 0. Slot boundaries are not checked.
- `rd` and `wr` are never asserted together. `cs` is high exactly when `rd` or `wr` is high.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `aborted` = 0.
  - `words_done` = 0.
  - `mmio_cs`, `mmio_rd`, `mmio_wr` = 0.
  - `mmio_addr` = 0, `mmio_wr_data` = 0.
- Reset asserted mid-transfer returns the block to IDLE immediately. No partial bus cycle follows.
- All bus outputs are registered, i.e. Moore outputs of state plus registers.
- Start accepted on edge 0 → first RD cycle is cycle 1.
- Copy throughput: 2 cycles per word. A transfer of N words has `done` in cycle 2N+1.
- Fill throughput: 1 cycle per word. `done` is in cycle N+1.
- `len`=0: `done` in cycle 1, with zero bus cycles.

## Configuration
- Macro `MMIO_MOVER_FILL_EN`.
- Defined: the `fill_mode` and `fill_data` ports exist, and the WR→WR fill path is built.
- Undefined: those ports are absent, copy mode is the only mode, and the fill path logic is removed.

## Structure
- Package `mmio_mover_pkg`, containing:
  - `state_t` enum (IDLE, RD, WR, DONE).
  - Constants `SLOT_W`=6 and `REG_W`=5.
  - A helper function that builds an address from slot and register numbers.
- One sub-module, `mmio_mover_addr_gen`: a loadable address register with an optional increment enable. It is instantiated twice, once for the source and once for the destination.

## Test plan
- Copy: `src_addr`=slot 3 reg 0 (GPI model returns 32'hA5), `dst_addr`=slot 2 reg 0, `len`=1 → RD then WR of 32'hA5, `done` in cycle 3, `words_done`=1.
- Copy with increment: `len`=4, `src_inc`=`dst_inc`=1, source regs 0..3 return 1..4 → writes 1,2,3,4 to consecutive destination regs, alternating RD/WR, `done` in cycle 9.
- FIFO source: `src_inc`=0, `len`=3 → all three reads hit the same address; destination addresses increment.
- Abort: abort during the second RD of `len`=5 → exactly 1 write, `aborted`=1, `words_done`=1.
- Wrap and zero length: `dst_addr`=21'h1FFFFF with `len`=2 → second write goes to address 0. Separately, `len`=0 → `done` in cycle 1 with no `cs` activity.
- Fill (macro defined): `fill_data`=32'hDEADBEEF, `len`=3 → three back-to-back WR cycles, `done` in cycle 4. Also assert async `reset` mid-fill → all bus strobes 0 immediately.
